// File: rtl/ts_packet_mux.sv
// rtl/ts_packet_mux.sv - N-channel TS packet multiplexer with FWFT output FIFO; TS_PKT_CNT_EN builds pkt_cnt
module ts_packet_mux #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 188,
    parameter int DEPTH   = 512
) (
    input  logic                       clk2,
    input  logic                       rst,
    input  logic [N_CH*DATA_W-1:0]     data_in,
    input  logic [N_CH-1:0]            valid_in,
    input  logic [N_CH-1:0]            sync_in,
    input  logic [$clog2(N_CH)-1:0]    sel,
    input  logic                       rr_mode,
    input  logic                       en_mux,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          data_out,
    output logic                       valid_out,
    output logic                       sync_out,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       sync_err,
    output logic [15:0]                pkt_cnt
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(PKT_LEN + 1);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   cur_ch, cur_ch_nxt, act_ch, next_ch;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
    logic              sel_valid, sel_sync;
    logic [DATA_W-1:0] sel_data;
    logic              push, push_sync, pop;
    logic              set_ovf, set_serr, pkt_done;

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   head;

    // In fixed mode the select takes effect in the same cycle the sync is seen in IDLE.
    always_comb begin
        act_ch = cur_ch;
        if (state == IDLE && en_mux && !rr_mode)
            act_ch = sel;
    end

    assign sel_valid = valid_in[act_ch];
    assign sel_sync  = sync_in[act_ch] & sel_valid;
    assign sel_data  = data_in[act_ch*DATA_W +: DATA_W];
    assign next_ch   = (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + CH_W'(1);

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_ch   <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cur_ch   <= cur_ch_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_ch_nxt   = cur_ch;
        byte_cnt_nxt = byte_cnt;
        push         = 1'b0;
        push_sync    = 1'b0;
        set_ovf      = 1'b0;
        set_serr     = 1'b0;
        pkt_done     = 1'b0;
        case (state)
            IDLE, DROP: begin
                if (en_mux) begin
                    cur_ch_nxt = act_ch;
                    if (sel_sync) begin
                        if (!fifo_full) begin
                            push         = 1'b1;
                            push_sync    = 1'b1;
                            byte_cnt_nxt = CNT_W'(1);
                            state_nxt    = PASS;
                        end else begin
                            set_ovf      = 1'b1;
                            byte_cnt_nxt = '0;
                            state_nxt    = DROP;
                        end
                    end
                end
            end
            PASS: begin
                if (sel_valid) begin
                    if (fifo_full) begin
                        set_ovf      = 1'b1;
                        byte_cnt_nxt = '0;
                        state_nxt    = DROP;
                    end else if (sel_sync) begin
                        // Early sync restarts the packet; the truncated one is never counted.
                        set_serr     = 1'b1;
                        push         = 1'b1;
                        push_sync    = 1'b1;
                        byte_cnt_nxt = CNT_W'(1);
                    end else if (byte_cnt == CNT_W'(PKT_LEN - 1)) begin
                        push         = 1'b1;
                        pkt_done     = 1'b1;
                        byte_cnt_nxt = '0;
                        state_nxt    = IDLE;
                        if (rr_mode)
                            cur_ch_nxt = next_ch;
                    end else begin
                        push         = 1'b1;
                        byte_cnt_nxt = byte_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                byte_cnt_nxt = '0;
            end
        endcase
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_level == (AW+1)'(DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign valid_out  = ~fifo_empty;
    assign pop        = valid_out & out_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign data_out   = fifo_empty ? '0 : head[DATA_W-1:0];
    assign sync_out   = ~fifo_empty & head[DATA_W];

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !fifo_full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk2) begin
        if (push && !fifo_full)
            mem[wr_ptr[AW-1:0]] <= {push_sync, sel_data};
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (set_ovf)
                overflow <= 1'b1;
            if (set_serr)
                sync_err <= 1'b1;
        end
    end

`ifdef TS_PKT_CNT_EN
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst)
            pkt_cnt <= '0;
        else if (pkt_done)
            pkt_cnt <= pkt_cnt + 16'd1;
    end
`else
    logic pkt_done_unused;
    assign pkt_done_unused = pkt_done;
    assign pkt_cnt         = '0;
`endif

endmodule

// File: tb/tb_ts_packet_mux.sv
// tb/tb_ts_packet_mux.sv - randomized self-checking bench for ts_packet_mux against a packet-level stream model
module tb_ts_packet_mux;
    localparam int N_CH = 4, DATA_W = 8, PKT_LEN = 188, DEPTH = 512;

    logic                   clk2 = 1'b0;
    logic                   rst = 1'b1;
    logic [N_CH*DATA_W-1:0] data_in = '0;
    logic [N_CH-1:0]        valid_in = '0;
    logic [N_CH-1:0]        sync_in = '0;
    logic [1:0]             sel = '0;
    logic                   rr_mode = 1'b0;
    logic                   en_mux = 1'b1;
    logic                   out_ready = 1'b0;
    logic [DATA_W-1:0]      data_out;
    logic                   valid_out, sync_out, fifo_full, fifo_empty;
    logic [9:0]             fifo_level;
    logic                   overflow, sync_err;
    logic [15:0]            pkt_cnt;

    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    int n_assert = 0;
    int n_fail = 0;
    int rdy_mode = 0;

    always #5 clk2 = ~clk2;

    ts_packet_mux #(.N_CH(N_CH), .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .DEPTH(DEPTH)) dut (
        .clk2(clk2), .rst(rst), .data_in(data_in), .valid_in(valid_in), .sync_in(sync_in),
        .sel(sel), .rr_mode(rr_mode), .en_mux(en_mux), .out_ready(out_ready),
        .data_out(data_out), .valid_out(valid_out), .sync_out(sync_out),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .overflow(overflow), .sync_err(sync_err), .pkt_cnt(pkt_cnt)
    );

    // Channel k, packet position n: 0x47 sync byte, then 0x10*k + n.
    function automatic logic [8:0] ts_word(int ch, int n);
        logic [7:0] b;
        b = (n == 0) ? 8'h47 : 8'((16 * ch + n) & 255);
        return {(n == 0), b};
    endfunction

    function automatic logic [15:0] exp_cnt(int n);
        logic [15:0] r;
        r = 16'(n);
`ifndef TS_PKT_CNT_EN
        r = '0;
`endif
        return r;
    endfunction

    function automatic int stream_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk2); #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3, 0) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk2)
        if (!rst && valid_out && out_ready) got.push_back({sync_out, data_out});

    task automatic do_reset();
        rst = 1'b1;
        valid_in = '0;
        sync_in = '0;
        data_in = '0;
        repeat (2) @(posedge clk2);
        #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic drive_pos(int n, int gap_max);
        int gap;
        logic [8:0] w;
        gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        repeat (gap) begin @(posedge clk2); #1; end
        for (int k = 0; k < N_CH; k++) begin
            w = ts_word(k, n);
            data_in[k*DATA_W +: DATA_W] = w[7:0];
        end
        valid_in = '1;
        sync_in = (n == 0) ? '1 : '0;
        @(posedge clk2); #1;
        valid_in = '0;
        sync_in = '0;
    endtask

    task automatic drain(string name);
        int c;
        c = 0;
        while (!fifo_empty && c < 6000) begin @(posedge clk2); #1; c++; end
        repeat (2) @(posedge clk2);
        #1;
        n_assert++;
        if (!fifo_empty) begin n_fail++; $display("FAIL %s drain_timeout: fifo_level %0d, required 0", name, fifo_level); end
    endtask

    task automatic test_reset();
        rdy_mode = 0;
        do_reset();
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_empty: got %b required 1", fifo_empty); end
        n_assert++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_full: got %b required 0", fifo_full); end
        n_assert++; if (fifo_level !== 10'd0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d required 0", fifo_level); end
        n_assert++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b required 0", valid_out); end
        n_assert++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h required 00", data_out); end
        n_assert++; if (sync_out !== 1'b0) begin n_fail++; $display("FAIL reset_sync_out: got %b required 0", sync_out); end
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        n_assert++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b required 0", sync_err); end
        n_assert++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d required 0", pkt_cnt); end
    endtask

    task automatic test_fixed();
        int d;
        rdy_mode = 1; rr_mode = 1'b0; sel = 2'd2; en_mux = 1'b1;
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int n = 0; n < PKT_LEN; n++) begin
                drive_pos(n, 2);
                exp_q.push_back(ts_word(2, n));
            end
        drain("fixed");
        d = stream_diff();
        n_assert++; if (d != -1) begin n_fail++; $display("FAIL fixed_stream: word %0d got %h required %h (%0d words, required %0d)", d, (d < got.size()) ? got[d] : 9'h1ff, (d < exp_q.size()) ? exp_q[d] : 9'h1ff, got.size(), exp_q.size()); end
        n_assert++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL fixed_sync_err: got %b required 0", sync_err); end
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fixed_overflow: got %b required 0", overflow); end
        n_assert++; if (pkt_cnt !== exp_cnt(3)) begin n_fail++; $display("FAIL fixed_pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt(3)); end
    endtask

    task automatic test_round_robin();
        int d;
        rdy_mode = 1; rr_mode = 1'b1; sel = 2'd3;
        do_reset();
        for (int p = 0; p < 8; p++)
            for (int n = 0; n < PKT_LEN; n++) begin
                drive_pos(n, 1);
                exp_q.push_back(ts_word(p % N_CH, n));
            end
        drain("rr");
        d = stream_diff();
        n_assert++; if (d != -1) begin n_fail++; $display("FAIL rr_stream: word %0d got %h required %h (%0d words, required %0d)", d, (d < got.size()) ? got[d] : 9'h1ff, (d < exp_q.size()) ? exp_q[d] : 9'h1ff, got.size(), exp_q.size()); end
        n_assert++; if (pkt_cnt !== exp_cnt(8)) begin n_fail++; $display("FAIL rr_pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt(8)); end
    endtask

    task automatic test_sel_switch();
        int d;
        rdy_mode = 1; rr_mode = 1'b0; sel = 2'd1;
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int n = 0; n < PKT_LEN; n++) begin
                if (p == 0 && n == 50) sel = 2'd3;
                drive_pos(n, 1);
                exp_q.push_back(ts_word((p == 0) ? 1 : 3, n));
            end
        drain("sel_switch");
        d = stream_diff();
        n_assert++; if (d != -1) begin n_fail++; $display("FAIL sel_switch_stream: word %0d got %h required %h (%0d words, required %0d)", d, (d < got.size()) ? got[d] : 9'h1ff, (d < exp_q.size()) ? exp_q[d] : 9'h1ff, got.size(), exp_q.size()); end
        n_assert++; if (pkt_cnt !== exp_cnt(3)) begin n_fail++; $display("FAIL sel_switch_pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt(3)); end
    endtask

    task automatic test_sync_err();
        int d;
        rdy_mode = 1; rr_mode = 1'b0; sel = 2'd0;
        do_reset();
        for (int n = 0; n < 100; n++) begin
            drive_pos(n, 1);
            exp_q.push_back(ts_word(0, n));
        end
        for (int p = 0; p < 2; p++)
            for (int n = 0; n < PKT_LEN; n++) begin
                drive_pos(n, 1);
                exp_q.push_back(ts_word(0, n));
            end
        drain("sync_err");
        d = stream_diff();
        n_assert++; if (d != -1) begin n_fail++; $display("FAIL sync_err_stream: word %0d got %h required %h (%0d words, required %0d)", d, (d < got.size()) ? got[d] : 9'h1ff, (d < exp_q.size()) ? exp_q[d] : 9'h1ff, got.size(), exp_q.size()); end
        n_assert++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_flag: got %b required 1", sync_err); end
        n_assert++; if (pkt_cnt !== exp_cnt(2)) begin n_fail++; $display("FAIL sync_err_pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt(2)); end
    endtask

    task automatic test_overflow();
        int d;
        rdy_mode = 2; rr_mode = 1'b0; sel = 2'd1;
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int n = 0; n < PKT_LEN; n++) begin
                drive_pos(n, 0);
                if (p * PKT_LEN + n < DEPTH) exp_q.push_back(ts_word(1, n));
            end
        n_assert++; if (fifo_level !== 10'(DEPTH)) begin n_fail++; $display("FAIL ovf_level: got %0d required %0d", fifo_level, DEPTH); end
        n_assert++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b required 1", fifo_full); end
        n_assert++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        rdy_mode = 1;
        repeat (40) @(posedge clk2);
        #1;
        for (int p = 0; p < 2; p++)
            for (int n = 0; n < PKT_LEN; n++) begin
                drive_pos(n, 2);
                exp_q.push_back(ts_word(1, n));
            end
        drain("overflow");
        d = stream_diff();
        n_assert++; if (d != -1) begin n_fail++; $display("FAIL ovf_stream: word %0d got %h required %h (%0d words, required %0d)", d, (d < got.size()) ? got[d] : 9'h1ff, (d < exp_q.size()) ? exp_q[d] : 9'h1ff, got.size(), exp_q.size()); end
        n_assert++; if (pkt_cnt !== exp_cnt(4)) begin n_fail++; $display("FAIL ovf_pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt(4)); end
    endtask

    task automatic test_reset_mid();
        int d;
        rdy_mode = 2; rr_mode = 1'b0; sel = 2'd0;
        do_reset();
        for (int n = 0; n < 100; n++) drive_pos(n, 0);
        n_assert++; if (fifo_level !== 10'd100) begin n_fail++; $display("FAIL mid_level_before: got %0d required 100", fifo_level); end
        #3;
        rst = 1'b1;
        #1;
        n_assert++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid_out: got %b required 0", valid_out); end
        n_assert++; if (fifo_level !== 10'd0) begin n_fail++; $display("FAIL mid_fifo_level: got %0d required 0", fifo_level); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_fifo_empty: got %b required 1", fifo_empty); end
        n_assert++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_data_out: got %h required 00", data_out); end
        n_assert++; if (sync_out !== 1'b0) begin n_fail++; $display("FAIL mid_sync_out: got %b required 0", sync_out); end
        got.delete();
        exp_q.delete();
        @(posedge clk2); #1;
        rst = 1'b0;
        rdy_mode = 1;
        for (int n = 100; n < PKT_LEN; n++) drive_pos(n, 1);
        for (int n = 0; n < PKT_LEN; n++) begin
            drive_pos(n, 1);
            exp_q.push_back(ts_word(0, n));
        end
        drain("reset_mid");
        d = stream_diff();
        n_assert++; if (d != -1) begin n_fail++; $display("FAIL mid_stream: word %0d got %h required %h (%0d words, required %0d)", d, (d < got.size()) ? got[d] : 9'h1ff, (d < exp_q.size()) ? exp_q[d] : 9'h1ff, got.size(), exp_q.size()); end
        n_assert++; if (pkt_cnt !== exp_cnt(1)) begin n_fail++; $display("FAIL mid_pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt(1)); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_sel_switch();
        test_sync_err();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
